// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address, and fills the IF/ID register with fetched words or bubbles.
// Handles decode stalls, downstream redirects, halting on ECALL/EBREAK,
// and a count of instructions that were actually captured.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_id,
  output logic [31:0] pc4_id,
  output logic [31:0] inst_id,
  output logic        valid_id,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_d, pc4_id_d, inst_id_d, fetch_count_d;
  logic        valid_id_d;
  logic [31:0] pc_plus4;
  logic        is_halt_inst;

  assign imem_addr    = pc_q;
  assign halted       = (state_q == HALT);
  assign pc_plus4     = pc_q + 32'd4;
  assign is_halt_inst = (imem_inst == ECALL_INST) || (imem_inst == EBREAK_INST);

  // Next-state and next-IF/ID selection: redirect beats stall beats normal flow.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    pc_id_d       = pc_id;
    pc4_id_d      = pc4_id;
    inst_id_d     = inst_id;
    valid_id_d    = valid_id;
    fetch_count_d = fetch_count;

    if (redirect) begin
      // Wrong-path word is dropped; pc_id/pc4_id keep their old values.
      pc_d       = {redirect_pc[31:2], 2'b00};
      inst_id_d  = NOP_INST;
      valid_id_d = 1'b0;
      state_d    = RUN;
    end else if (!stall) begin
      unique case (state_q)
        RUN: begin
          pc_id_d       = pc_q;
          pc4_id_d      = pc_plus4;
          inst_id_d     = imem_inst;
          valid_id_d    = 1'b1;
          fetch_count_d = fetch_count + 32'd1;
          if (is_halt_inst) begin
            // PC parks on the trap instruction so a debugger sees where we stopped.
            state_d = HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
        HALT: begin
          inst_id_d  = NOP_INST;
          valid_id_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pc_id       <= 32'd0;
      pc4_id      <= 32'd0;
      inst_id     <= NOP_INST;
      valid_id    <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_id       <= pc_id_d;
      pc4_id      <= pc4_id_d;
      inst_id     <= inst_id_d;
      valid_id    <= valid_id_d;
      fetch_count <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a vector table of inputs and
// hand-computed expected outputs, fed through a scoreboard queue, followed
// by a few hand-written multi-cycle sequences.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_inst;
  logic [31:0] pc_id, pc4_id, inst_id, fetch_count;
  logic        valid_id, halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, stall, redirect;
    logic [31:0] rpc;
    logic [31:0] e_addr, e_pc_id, e_pc4, e_inst;
    logic        e_valid, e_halted;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[28];
  vec_t exp_q[$];

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_id       (pc_id),
    .pc4_id      (pc4_id),
    .inst_id     (inst_id),
    .valid_id    (valid_id),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: address-derived words, with traps planted at 0x108 / 0x208.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h108) return ECALL;
    if (a == 32'h208) return EBREAK;
    return {8'hC0, a[23:0]};
  endfunction

  always_comb imem_inst = word_at(imem_addr);

  function automatic vec_t mk(input logic r, input logic s, input logic rd,
                              input logic [31:0] rpc, input logic [31:0] a,
                              input logic [31:0] pid, input logic [31:0] p4,
                              input logic [31:0] inst, input logic v,
                              input logic h, input logic [31:0] c);
    vec_t t;
    t.rst = r; t.stall = s; t.redirect = rd; t.rpc = rpc;
    t.e_addr = a; t.e_pc_id = pid; t.e_pc4 = p4; t.e_inst = inst;
    t.e_valid = v; t.e_halted = h; t.e_cnt = c;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic sample_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    //             rst stl rd  rpc            addr           pc_id          pc4            inst                 v  h  cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         NOP,                 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         NOP,                 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,         32'h4,         32'h0,         32'h4,         word_at(32'h0),      1, 0, 1);
    vecs[3]  = mk(0, 0, 0, 32'h0,         32'h8,         32'h4,         32'h8,         word_at(32'h4),      1, 0, 2);
    vecs[4]  = mk(0, 0, 0, 32'h0,         32'hC,         32'h8,         32'hC,         word_at(32'h8),      1, 0, 3);
    vecs[5]  = mk(0, 1, 0, 32'h0,         32'hC,         32'h8,         32'hC,         word_at(32'h8),      1, 0, 3);
    vecs[6]  = mk(0, 1, 0, 32'h0,         32'hC,         32'h8,         32'hC,         word_at(32'h8),      1, 0, 3);
    vecs[7]  = mk(0, 0, 0, 32'h0,         32'h10,        32'hC,         32'h10,        word_at(32'hC),      1, 0, 4);
    vecs[8]  = mk(0, 1, 1, 32'h103,       32'h100,       32'hC,         32'h10,        NOP,                 0, 0, 4);
    vecs[9]  = mk(0, 0, 0, 32'h0,         32'h104,       32'h100,       32'h104,       word_at(32'h100),    1, 0, 5);
    vecs[10] = mk(0, 0, 0, 32'h0,         32'h108,       32'h104,       32'h108,       word_at(32'h104),    1, 0, 6);
    vecs[11] = mk(0, 0, 0, 32'h0,         32'h108,       32'h108,       32'h10C,       ECALL,               1, 1, 7);
    vecs[12] = mk(0, 0, 0, 32'h0,         32'h108,       32'h108,       32'h10C,       NOP,                 0, 1, 7);
    vecs[13] = mk(0, 0, 0, 32'h0,         32'h108,       32'h108,       32'h10C,       NOP,                 0, 1, 7);
    vecs[14] = mk(0, 0, 0, 32'h0,         32'h108,       32'h108,       32'h10C,       NOP,                 0, 1, 7);
    vecs[15] = mk(0, 1, 0, 32'h0,         32'h108,       32'h108,       32'h10C,       NOP,                 0, 1, 7);
    vecs[16] = mk(0, 0, 1, 32'h40,        32'h40,        32'h108,       32'h10C,       NOP,                 0, 0, 7);
    vecs[17] = mk(0, 0, 0, 32'h0,         32'h44,        32'h40,        32'h44,        word_at(32'h40),     1, 0, 8);
    vecs[18] = mk(0, 0, 1, 32'h108,       32'h108,       32'h40,        32'h44,        NOP,                 0, 0, 8);
    vecs[19] = mk(0, 0, 1, 32'h20,        32'h20,        32'h40,        32'h44,        NOP,                 0, 0, 8);
    vecs[20] = mk(0, 0, 0, 32'h0,         32'h24,        32'h20,        32'h24,        word_at(32'h20),     1, 0, 9);
    vecs[21] = mk(0, 0, 1, 32'h208,       32'h208,       32'h20,        32'h24,        NOP,                 0, 0, 9);
    vecs[22] = mk(0, 1, 0, 32'h0,         32'h208,       32'h20,        32'h24,        NOP,                 0, 0, 9);
    vecs[23] = mk(0, 0, 0, 32'h0,         32'h208,       32'h208,       32'h20C,       EBREAK,              1, 1, 10);
    vecs[24] = mk(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h208,       32'h20C,       NOP,                 0, 0, 10);
    vecs[25] = mk(0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         32'hC0FF_FFFC,       1, 0, 11);
    vecs[26] = mk(1, 1, 1, 32'h40,        32'h0,         32'h0,         32'h0,         NOP,                 0, 0, 0);
    vecs[27] = mk(0, 0, 0, 32'h0,         32'h4,         32'h0,         32'h4,         word_at(32'h0),      1, 0, 1);

    // Table pass: expectations are queued as stimulus is driven, then
    // popped and compared once the edge has produced the DUT's outputs.
    for (int i = 0; i < 28; i++) begin
      vec_t e;
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      exp_q.push_back(vecs[i]);
      sample_edge();
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at vector %0d", i);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d imem_addr", i),   imem_addr,          e.e_addr);
        check($sformatf("v%0d pc_id", i),       pc_id,              e.e_pc_id);
        check($sformatf("v%0d pc4_id", i),      pc4_id,             e.e_pc4);
        check($sformatf("v%0d inst_id", i),     inst_id,            e.e_inst);
        check($sformatf("v%0d valid_id", i),    {31'd0, valid_id},  {31'd0, e.e_valid});
        check($sformatf("v%0d halted", i),      {31'd0, halted},    {31'd0, e.e_halted});
        check($sformatf("v%0d fetch_count", i), fetch_count,        e.e_cnt);
      end
    end

    // Straight-line burst: five free edges from PC=0x4, count=1.
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 32'h0);
      sample_edge();
      check($sformatf("burst%0d valid_id", k), {31'd0, valid_id}, 32'd1);
    end
    check("burst imem_addr",   imem_addr,   32'h18);
    check("burst fetch_count", fetch_count, 32'd6);
    check("burst pc4_id",      pc4_id,      32'h18);

    // Redirect onto the ECALL, then wait (bounded) for halt to assert.
    drive(0, 0, 1, 32'h108);
    sample_edge();
    check("hseq bubble valid_id", {31'd0, valid_id}, 32'd0);
    begin
      int waited = 0;
      drive(0, 0, 0, 32'h0);
      while (!halted && waited < 4) begin
        sample_edge();
        waited++;
      end
      check("hseq halted_within_budget", {31'd0, halted}, 32'd1);
      check("hseq halt_latency", waited, 32'd1);
    end
    check("hseq fetch_count", fetch_count, 32'd7);
    check("hseq imem_addr",   imem_addr,   32'h108);

    // Reset while halted clears everything on that edge.
    drive(1, 0, 0, 32'h0);
    sample_edge();
    check("rst_halt halted",      {31'd0, halted},   32'd0);
    check("rst_halt valid_id",    {31'd0, valid_id}, 32'd0);
    check("rst_halt inst_id",     inst_id,           NOP);
    check("rst_halt fetch_count", fetch_count,       32'd0);
    check("rst_halt imem_addr",   imem_addr,         32'h0);
    drive(0, 0, 0, 32'h0);
    sample_edge();
    check("rst_halt first_fetch", inst_id, word_at(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 3-stage RISC-V pipeline. Holds the program counter and drives the combinational instruction memory address. Captures the fetched word into the IF/ID pipeline register consumed by decode/execute. Supports decode-side stall, branch/jump redirect with bubble insertion, halt on ECALL/EBREAK, and a retired-fetch counter for bring-up debug.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INST, 32'h0000_0013: word placed in IF/ID on bubbles (addi x0,x0,0).
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals current PC (combinational from PC register).
- imem_inst  input  32  instruction word returned combinationally for imem_addr in the same cycle.
- stall  input  1  decode cannot accept; hold PC and IF/ID.
- redirect  input  1  taken branch/jump resolved downstream.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced to 00).
- pc_id  output  32  IF/ID: address of inst_id.
- pc4_id  output  32  IF/ID: pc_id + 4.
- inst_id  output  32  IF/ID: instruction word.
- valid_id  output  1  IF/ID holds a real instruction (0 = bubble).
- halted  output  1  fetch stopped after ECALL/EBREAK.
- fetch_count  output  32  number of valid instructions captured into IF/ID; wraps modulo 2^32.

## Operation
- State machine: RUN, HALT. Reset enters RUN.
- Priority each rising edge: rst > redirect > stall > normal.
- rst: PC=RESET_PC; pc_id=0, pc4_id=0, inst_id=NOP_INST, valid_id=0, halted=0, fetch_count=0, state RUN.
- redirect (either state, regardless of stall): PC={redirect_pc[31:2],2'b00}; IF/ID loaded with bubble (inst_id=NOP_INST, valid_id=0, pc_id/pc4_id hold previous values); state RUN, halted=0; fetch_count unchanged.
- stall (no redirect): PC, IF/ID, state, fetch_count all hold.
- RUN, normal: IF/ID <= {PC, PC+4, imem_inst}, valid_id=1; PC <= PC+4 (mod 2^32); fetch_count += 1.
  - If captured imem_inst is 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK): state -> HALT, halted=1, PC holds at the ECALL address (not incremented).
- HALT, normal: PC holds; IF/ID loaded with bubble (valid_id=0, inst_id=NOP_INST); fetch_count holds. Only redirect or rst leaves HALT.
- PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- imem_addr always reflects PC, including in HALT and during stall.

## Timing
- Fetch-to-IF/ID latency: 1 cycle (word at imem_addr in cycle N appears on inst_id after edge N).
- Redirect penalty: exactly 1 bubble in IF/ID; target instruction valid in IF/ID one edge after the bubble.
- Stall has zero-cycle effect: the edge on which stall=1 changes nothing.
- Halt: halted rises on the same edge the ECALL enters IF/ID (ECALL itself has valid_id=1); bubbles follow from the next edge.
- Redirect and ECALL capture on the same edge: redirect wins; no halt; ECALL is not counted.
- Stall while imem_inst is ECALL: ECALL not captured; no halt until an unstalled edge.
- rst asserted mid-operation (any state, any stall/redirect): reset values on that edge; first fetch at RESET_PC captured on the first edge with rst=0.

## Test plan
- Reset and straight-line fetch: rst 2 cycles, imem returns addr-based words -> after 3 free edges pc_id=0x8, pc4_id=0xC, valid_id=1, fetch_count=3, imem_addr=0xC.
- Stall: assert stall 2 cycles at PC=0x8 -> PC, IF/ID, fetch_count frozen for both edges; on release inst at 0x8 captured next edge.
- Redirect with stall: redirect=1, redirect_pc=0x103, stall=1 -> next edge PC=0x100, valid_id=0, inst_id=0x00000013; following edge pc_id=0x100, valid_id=1.
- Halt: imem returns 0x00000073 at 0x10 -> valid_id=1, inst_id=0x73, halted=1; next 3 edges valid_id=0, PC=0x10, fetch_count constant; redirect to 0x40 -> halted=0, fetch resumes at 0x40.
- ECALL vs redirect same edge: ECALL at PC, redirect to 0x20 -> halted stays 0, bubble, fetch_count not incremented.
- Wrap and mid-run reset: redirect to 0xFFFFFFFC, one free edge -> PC=0x0, pc4_id=0x0; then rst=1 during stall -> all outputs at reset values next edge.
